// File: rtl/jtag_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// jtag_pkg: TAP state encodings, IR capture pattern, TMS transition fn.
// Revision: 1.0
// ------------------------------------------------------------------
package jtag_pkg;

  typedef enum logic [3:0] {
    TAP_EX2_DR   = 4'h0,
    TAP_EX1_DR   = 4'h1,
    TAP_SH_DR    = 4'h2,
    TAP_PAUSE_DR = 4'h3,
    TAP_SEL_IR   = 4'h4,
    TAP_UPD_DR   = 4'h5,
    TAP_CAP_DR   = 4'h6,
    TAP_SEL_DR   = 4'h7,
    TAP_EX2_IR   = 4'h8,
    TAP_EX1_IR   = 4'h9,
    TAP_SH_IR    = 4'hA,
    TAP_PAUSE_IR = 4'hB,
    TAP_RTI      = 4'hC,
    TAP_UPD_IR   = 4'hD,
    TAP_CAP_IR   = 4'hE,
    TAP_TLR      = 4'hF
  } tap_state_e;

  // Low two bits loaded into the IR shift register in Capture-IR
  localparam logic [1:0] c_IR_CAPTURE   = 2'b01;
  localparam int         c_IDCODE_WIDTH = 32;

  function automatic tap_state_e next_state(input tap_state_e s, input logic tms);
    tap_state_e n;
    n = TAP_TLR;
    case (s)
      TAP_TLR:      n = tms ? TAP_TLR    : TAP_RTI;
      TAP_RTI:      n = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR:   n = tms ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR:   n = tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_SH_DR:    n = tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_EX1_DR:   n = tms ? TAP_UPD_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR: n = tms ? TAP_EX2_DR : TAP_PAUSE_DR;
      TAP_EX2_DR:   n = tms ? TAP_UPD_DR : TAP_SH_DR;
      TAP_UPD_DR:   n = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR:   n = tms ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR:   n = tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_SH_IR:    n = tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_EX1_IR:   n = tms ? TAP_UPD_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR: n = tms ? TAP_EX2_IR : TAP_PAUSE_IR;
      TAP_EX2_IR:   n = tms ? TAP_UPD_IR : TAP_SH_IR;
      TAP_UPD_IR:   n = tms ? TAP_SEL_DR : TAP_RTI;
      default:      n = TAP_TLR;
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_tap_param_if.sv
`default_nettype none
// ------------------------------------------------------------------
// jtag_tap_param_if: scan-side and user-side signals of the TAP.
// Revision: 1.0
// ------------------------------------------------------------------
interface jtag_tap_param_if #(
  parameter int IR_WIDTH      = 4,
  parameter int NUM_USER_DR   = 2,
  parameter int USER_DR_WIDTH = 8
);
  logic                                   TMS;
  logic                                   TDI;
  logic                                   TDO;
  logic                                   TDO_EN;
  logic [3:0]                             state;
  logic                                   TLR;
  logic [IR_WIDTH-1:0]                    IR_OUT;
  logic [NUM_USER_DR-1:0]                 USER_SEL;
  logic [NUM_USER_DR*USER_DR_WIDTH-1:0]   USER_CAPTURE_DATA;
  logic [NUM_USER_DR*USER_DR_WIDTH-1:0]   USER_UPDATE_DATA;
  logic [NUM_USER_DR-1:0]                 USER_UPDATE_STB;

  modport master (
    output TMS, TDI, USER_CAPTURE_DATA,
    input  TDO, TDO_EN, state, TLR, IR_OUT, USER_SEL, USER_UPDATE_DATA, USER_UPDATE_STB
  );

  modport slave (
    input  TMS, TDI, USER_CAPTURE_DATA,
    output TDO, TDO_EN, state, TLR, IR_OUT, USER_SEL, USER_UPDATE_DATA, USER_UPDATE_STB
  );
endinterface
`default_nettype wire

// File: rtl/jtag_tap_param_tap_fsm.sv
`default_nettype none
// ------------------------------------------------------------------
// tap_fsm: 16-state TAP controller with registered state-decode strobes.
// Revision: 1.0
// ------------------------------------------------------------------
module tap_fsm
  import jtag_pkg::*;
(
  input  wire        TCK,
  input  wire        TRST,
  input  wire        tms_i,
  output tap_state_e state_o,
  output logic       tlr_o,
  output logic       cap_ir_o,
  output logic       sh_ir_o,
  output logic       upd_ir_o,
  output logic       cap_dr_o,
  output logic       sh_dr_o,
  output logic       upd_dr_o
);

  tap_state_e state_q;
  tap_state_e state_d;
  logic       tlr_q;
  logic       cap_ir_q;
  logic       sh_ir_q;
  logic       upd_ir_q;
  logic       cap_dr_q;
  logic       sh_dr_q;
  logic       upd_dr_q;

  assign state_d = next_state(state_q, tms_i);

  // Strobes are decoded from the next state so they line up with state_q
  always_ff @(posedge TCK) begin
    if (TRST) begin
      state_q  <= TAP_TLR;
      tlr_q    <= 1'b1;
      cap_ir_q <= 1'b0;
      sh_ir_q  <= 1'b0;
      upd_ir_q <= 1'b0;
      cap_dr_q <= 1'b0;
      sh_dr_q  <= 1'b0;
      upd_dr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tlr_q    <= (state_d == TAP_TLR);
      cap_ir_q <= (state_d == TAP_CAP_IR);
      sh_ir_q  <= (state_d == TAP_SH_IR);
      upd_ir_q <= (state_d == TAP_UPD_IR);
      cap_dr_q <= (state_d == TAP_CAP_DR);
      sh_dr_q  <= (state_d == TAP_SH_DR);
      upd_dr_q <= (state_d == TAP_UPD_DR);
    end
  end

  assign state_o  = state_q;
  assign tlr_o    = tlr_q;
  assign cap_ir_o = cap_ir_q;
  assign sh_ir_o  = sh_ir_q;
  assign upd_ir_o = upd_ir_q;
  assign cap_dr_o = cap_dr_q;
  assign sh_dr_o  = sh_dr_q;
  assign upd_dr_o = upd_dr_q;

endmodule
`default_nettype wire

// File: rtl/jtag_tap_param.sv
`default_nettype none
// ------------------------------------------------------------------
// jtag_tap_param: parametrised 1149.1 TAP with IR, IDCODE, BYPASS and user DRs.
// Revision: 1.0
// ------------------------------------------------------------------
module jtag_tap_param
  import jtag_pkg::*;
#(
  parameter int                  IR_WIDTH      = 4,
  parameter logic [31:0]         IDCODE_VALUE  = 32'h1234_5679,
  parameter logic [IR_WIDTH-1:0] IDCODE_OPC    = IR_WIDTH'(4'h7),
  parameter logic [IR_WIDTH-1:0] BYPASS_OPC    = '1,
  parameter int                  NUM_USER_DR   = 2,
  parameter int                  USER_DR_WIDTH = 8,
  parameter logic [IR_WIDTH-1:0] USER_OPC_BASE = IR_WIDTH'(4'h8)
)(
  input  wire              TCK,
  input  wire              TRST,
  jtag_tap_param_if.slave  bus
);

  tap_state_e fsm_state;
  logic       tlr;
  logic       cap_ir;
  logic       sh_ir;
  logic       upd_ir;
  logic       cap_dr;
  logic       sh_dr;
  logic       upd_dr;

  tap_fsm u_tap_fsm (
    .TCK      (TCK),
    .TRST     (TRST),
    .tms_i    (bus.TMS),
    .state_o  (fsm_state),
    .tlr_o    (tlr),
    .cap_ir_o (cap_ir),
    .sh_ir_o  (sh_ir),
    .upd_ir_o (upd_ir),
    .cap_dr_o (cap_dr),
    .sh_dr_o  (sh_dr),
    .upd_dr_o (upd_dr)
  );

  logic [IR_WIDTH-1:0]                  ir_out_q;
  logic [IR_WIDTH-1:0]                  ir_sr_q;
  logic [c_IDCODE_WIDTH-1:0]            id_sr_q;
  logic                                 byp_q;
  logic [USER_DR_WIDTH-1:0]             user_sr_q [NUM_USER_DR];
  logic [NUM_USER_DR*USER_DR_WIDTH-1:0] upd_data_q;
  logic [NUM_USER_DR-1:0]               upd_stb_q;
  logic                                 tdo_q;
  logic                                 tdo_en_q;

  logic                                 byp_opc;
  logic                                 sel_id;
  logic                                 sel_byp;
  logic [NUM_USER_DR-1:0]               sel_user;
  logic [USER_DR_WIDTH-1:0]             user_shift_d [NUM_USER_DR];
  logic [USER_DR_WIDTH-1:0]             user_cap     [NUM_USER_DR];
  logic [NUM_USER_DR-1:0]               user_bit0;
  logic                                 dr_tdo;

  // The explicit BYPASS opcode wins over any overlapping decode
  assign byp_opc = (ir_out_q == BYPASS_OPC);
  assign sel_id  = !byp_opc && (ir_out_q == IDCODE_OPC);
  assign sel_byp = !sel_id && !(|sel_user);

  for (genvar k = 0; k < NUM_USER_DR; k++) begin : g_user
    localparam logic [IR_WIDTH-1:0] c_OPC = USER_OPC_BASE + IR_WIDTH'(k);

    assign sel_user[k]     = !byp_opc && (ir_out_q != IDCODE_OPC) && (ir_out_q == c_OPC);
    assign user_shift_d[k] = USER_DR_WIDTH'({bus.TDI, user_sr_q[k]} >> 1);
    assign user_cap[k]     = bus.USER_CAPTURE_DATA[k*USER_DR_WIDTH +: USER_DR_WIDTH];
    assign user_bit0[k]    = user_sr_q[k][0];
  end

  always_comb begin
    dr_tdo = byp_q;
    for (int k = 0; k < NUM_USER_DR; k++) begin
      if (sel_user[k]) begin
        dr_tdo = user_bit0[k];
      end
    end
    if (sel_id) begin
      dr_tdo = id_sr_q[0];
    end
  end

  always_ff @(posedge TCK) begin
    if (TRST) begin
      ir_out_q   <= IDCODE_OPC;
      ir_sr_q    <= '0;
      id_sr_q    <= '0;
      byp_q      <= 1'b0;
      for (int k = 0; k < NUM_USER_DR; k++) begin
        user_sr_q[k] <= '0;
      end
      upd_data_q <= '0;
      upd_stb_q  <= '0;
      tdo_q      <= 1'b0;
      tdo_en_q   <= 1'b0;
    end else begin
      upd_stb_q <= '0;

      if (tlr) begin
        ir_out_q <= IDCODE_OPC;
      end else if (upd_ir) begin
        ir_out_q <= ir_sr_q;
      end

      if (cap_ir) begin
        ir_sr_q <= IR_WIDTH'(c_IR_CAPTURE);
      end else if (sh_ir) begin
        ir_sr_q <= {bus.TDI, ir_sr_q[IR_WIDTH-1:1]};
      end

      if (sel_id) begin
        if (cap_dr) begin
          id_sr_q <= IDCODE_VALUE;
        end else if (sh_dr) begin
          id_sr_q <= {bus.TDI, id_sr_q[c_IDCODE_WIDTH-1:1]};
        end
      end

      if (sel_byp) begin
        if (cap_dr) begin
          byp_q <= 1'b0;
        end else if (sh_dr) begin
          byp_q <= bus.TDI;
        end
      end

      // Update slices only ever change here, never on an IR change
      for (int k = 0; k < NUM_USER_DR; k++) begin
        if (sel_user[k]) begin
          if (cap_dr) begin
            user_sr_q[k] <= user_cap[k];
          end else if (sh_dr) begin
            user_sr_q[k] <= user_shift_d[k];
          end
          if (upd_dr) begin
            upd_data_q[k*USER_DR_WIDTH +: USER_DR_WIDTH] <= user_sr_q[k];
            upd_stb_q[k] <= 1'b1;
          end
        end
      end

      if (sh_ir) begin
        tdo_q    <= ir_sr_q[0];
        tdo_en_q <= 1'b1;
      end else if (sh_dr) begin
        tdo_q    <= dr_tdo;
        tdo_en_q <= 1'b1;
      end else begin
        tdo_en_q <= 1'b0;
      end
    end
  end

  assign bus.TDO              = tdo_q;
  assign bus.TDO_EN           = tdo_en_q;
  assign bus.state            = fsm_state;
  assign bus.TLR              = tlr;
  assign bus.IR_OUT           = ir_out_q;
  assign bus.USER_SEL         = sel_user;
  assign bus.USER_UPDATE_DATA = upd_data_q;
  assign bus.USER_UPDATE_STB  = upd_stb_q;

endmodule
`default_nettype wire

// File: doc/jtag_tap_param.md
Name: jtag_tap_param

Overview:
Parametrised, self-contained JTAG TAP for the scan fabric. It combines the IEEE 1149.1 16-state controller, a configurable-width instruction register, IDCODE and BYPASS registers, and NUM_USER_DR user data registers. Each user data register has a parallel capture input and an update output with a strobe. It replaces the fixed 4-bit-IR TAP and DR glue, and feeds core-logic, BIST and LED muxes through its USER_* ports.

Parameters:
IR_WIDTH, 4, instruction register length (>=2)
IDCODE_VALUE, 32'h1234_5679, value captured by IDCODE; bit 0 must be 1
IDCODE_OPC, 4'h7, IDCODE opcode; loaded into IR on TLR
BYPASS_OPC, all ones, BYPASS opcode; any undecoded opcode also selects bypass
NUM_USER_DR, 2, number of user data registers (1..8)
USER_DR_WIDTH, 8, width of each user data register (>=1)
USER_OPC_BASE, 4'h8, user register k is selected by opcode USER_OPC_BASE+k

Ports:
TCK  in  1  TAP clock; the only clock
TRST  in  1  synchronous, active-high reset
TMS  in  1  test mode select, sampled on posedge TCK
TDI  in  1  test data in
TDO  out  1  registered test data out
TDO_EN  out  1  high while TDO carries valid shift data
state  out  4  current TAP state (IEEE encoding)
TLR  out  1  high in Test-Logic-Reset
IR_OUT  out  IR_WIDTH  latched instruction
USER_SEL  out  NUM_USER_DR  one-hot: user register k selected by IR_OUT
USER_CAPTURE_DATA  in  NUM_USER_DR*USER_DR_WIDTH  parallel capture values; slice k belongs to register k
USER_UPDATE_DATA  out  NUM_USER_DR*USER_DR_WIDTH  latched update values
USER_UPDATE_STB  out  NUM_USER_DR  one-cycle pulse when slice k is updated

Behaviour:
- Single clock TCK, posedge only. Reset is synchronous and active-high on TRST.
- TRST=1 sets:
  - state=TLR (4'hF), IR_OUT=IDCODE_OPC
  - TDO=0, TDO_EN=0
  - USER_UPDATE_DATA=0, USER_UPDATE_STB=0
- State encodings:
  - TLR F, RTI C
  - SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauseDR 3, Ex2DR 0, UpdDR 5
  - SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauseIR B, Ex2IR 8, UpdIR D
- Transitions follow the 1149.1 TMS graph exactly. Five consecutive TMS=1 reach TLR from any state.
- While state==TLR, IR_OUT is forced to IDCODE_OPC on every cycle.
- IR shifting:
  - In CapIR, the IR shift register loads {0..0,2'b01}.
  - In ShIR, each cycle: sr <= {TDI, sr[IR_WIDTH-1:1]}.
  - In UpdIR, IR_OUT <= sr.
- DR selection is decoded from IR_OUT: IDCODE_OPC → ID (32 bits), USER_OPC_BASE+k (k<NUM_USER_DR) → user k, all else → bypass (1 bit).
- DR capture in CapDR: ID loads IDCODE_VALUE, bypass loads 0, user k loads its capture slice.
- DR shift in ShDR: the selected register shifts right and TDI enters at its MSB. Unselected registers hold.
- DR update in UpdDR, only when user k is selected: slice k <= user shift register, and USER_UPDATE_STB[k]=1 for exactly that cycle. Every other cycle the strobe is 0.
- TDO timing:
  - On a cycle in ShDR or ShIR, TDO <= bit 0 of the active shift register (pre-shift value), and TDO_EN <= 1.
  - On all other cycles, TDO_EN <= 0 and TDO holds.
  - Net effect: TDO lags the shift by one TCK.
- Pause and Exit states hold all shift registers. Resuming ShDR continues without loss.
- Changing IR_OUT never alters USER_UPDATE_DATA.
- TRST in mid-shift: the partial data is discarded, no strobe is issued, and update data is cleared to 0.
- Shift lengths other than the register width are legal. Only the final register contents are updated.

Decomposition:
- Package jtag_pkg:
  - 4-bit TAP state enumeration and encodings
  - IR capture pattern constant
  - next_state function (state, TMS)
- Sub-module tap_fsm: TCK, TRST, TMS → state, TLR, and decoded capture/shift/update strobes for IR and DR.
- The top level holds the IR, the DR shift and update registers, and the TDO mux.

Test Plan:
1. TRST=1 for 1 cycle, then TMS=1 x5 → state=F, IR_OUT=4'h7, TDO_EN=0, USER_UPDATE_DATA=0.
2. From TLR, TMS 0,1,0,0 then 32 ShDR cycles → TDO bits LSB-first form 32'h12345679, TDO_EN high for 32 cycles.
3. IR scan of 4'h8 (TDI 0,0,0,1) → first two TDO bits 1,0 (the capture pattern); after UpdIR, IR_OUT=8 and USER_SEL=2'b01.
4. USER0 with USER_CAPTURE_DATA[7:0]=8'hA5, shifting in 8'h3C → TDO yields A5 LSB-first; in UpdDR, USER_UPDATE_DATA[7:0]=8'h3C and STB=2'b01 for exactly 1 cycle; slice [15:8] unchanged.
5. IR=4'hF (or undecoded 4'hC), ShDR with TDI 1,0,1,1 → TDO 0,1,0,1; no strobe.
6. ShDR with USER1 selected, PauseDR for 3 cycles, then resume for 4 more bits → update reflects all 8 bits. Repeat with TRST asserted mid-shift → state=F, IR_OUT=7, no STB, update data=0.
